hs32_flash_ctl: RTL

Read-only SPI flash controller for the hs32 user project. Sequences standard 0x03 READ transactions on the management-style flash pins, fetching one 32-bit little-endian word per request. Shares that single flash between two requesters, port 0 (instruction fetch) and port 1 (data load), using round-robin arbitration. Sits between the hs32 core's memory ports and the flash_csb/flash_clk/flash_io0/flash_io1 pins.

---
 rtl/hs32_flash_pkg.sv | 23 ++
 rtl/hs32_flash_rr_arb.sv | 29 ++
 rtl/hs32_flash_ctl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/hs32_flash_pkg.sv
// Shared types and constants for the hs32 read-only SPI flash controller.
package hs32_flash_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_DONE,
      S_DESEL
   } state_t;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam int         CMD_BITS  = 8;
   localparam int         ADDR_BITS = 24;
   localparam int         DATA_BITS = 32;

   // Bytes arrive first-byte-in-MSB from the shifter; the word is little-endian.
   function automatic logic [31:0] bswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/hs32_flash_rr_arb.sv
// Two-way round-robin arbiter; the pointer remembers the last granted port.
module hs32_flash_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       grant_en,
   output logic       gnt_valid,
   output logic       gnt_sel
);

   logic last;

   always_comb begin
      gnt_valid = |req;
      if (req[0] && req[1])
         gnt_sel = ~last;
      else
         gnt_sel = req[1];
   end

   // Reset points at port 1 so port 0 wins the first contested grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last <= 1'b1;
      else if (grant_en && gnt_valid)
         last <= gnt_sel;
   end

endmodule

// File: rtl/hs32_flash_ctl.sv
// Read-only SPI flash controller: one 0x03 READ per request, one 32-bit
// little-endian word returned, two requesters shared round-robin.
module hs32_flash_ctl
   import hs32_flash_pkg::*;
#(
   parameter int CLKDIV    = 1,
   parameter int DESEL_CYC = 2
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        p0_stb,
   input  logic [23:0] p0_addr,
   output logic        p0_ack,
   output logic [31:0] p0_dat,
   input  logic        p1_stb,
   input  logic [23:0] p1_addr,
   output logic        p1_ack,
   output logic [31:0] p1_dat,
   output logic        flash_csb,
   output logic        flash_clk,
   output logic        flash_io0,
   input  logic        flash_io1,
   output logic        busy
);

   localparam int TOT_BITS = CMD_BITS + ADDR_BITS + DATA_BITS;

   state_t      state;
   logic        sel;
   logic [30:0] tx;
   logic [31:0] rx;
   logic [5:0]  bit_cnt;
   logic [15:0] div_cnt;
   logic [15:0] desel_cnt;
   logic        arb_valid;
   logic        arb_sel;
   logic [23:0] gnt_addr;

   assign gnt_addr = arb_sel ? p1_addr : p0_addr;

   hs32_flash_rr_arb u_arb (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .req       ({p1_stb, p0_stb}),
      .grant_en  (state == S_IDLE),
      .gnt_valid (arb_valid),
      .gnt_sel   (arb_sel)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state     <= S_IDLE;
         sel       <= 1'b0;
         tx        <= '0;
         rx        <= '0;
         bit_cnt   <= '0;
         div_cnt   <= '0;
         desel_cnt <= '0;
         flash_csb <= 1'b1;
         flash_clk <= 1'b0;
         flash_io0 <= 1'b0;
         p0_ack    <= 1'b0;
         p1_ack    <= 1'b0;
         p0_dat    <= '0;
         p1_dat    <= '0;
         busy      <= 1'b0;
      end else begin
         p0_ack <= 1'b0;
         p1_ack <= 1'b0;
         case (state)
            S_IDLE: begin
               if (arb_valid) begin
                  sel       <= arb_sel;
                  // Command MSB goes straight to the pin; the rest queues in tx.
                  tx        <= {CMD_READ[6:0], gnt_addr[23:2], 2'b00};
                  flash_io0 <= CMD_READ[7];
                  flash_csb <= 1'b0;
                  flash_clk <= 1'b0;
                  bit_cnt   <= '0;
                  div_cnt   <= '0;
                  busy      <= 1'b1;
                  state     <= S_CMD;
               end
            end
            S_CMD, S_ADDR, S_DATA: begin
               if (div_cnt == 16'(CLKDIV - 1)) begin
                  div_cnt   <= '0;
                  flash_clk <= ~flash_clk;
                  if (!flash_clk) begin
                     rx <= {rx[30:0], flash_io1};
                  end else begin
                     // Falling edge closes the bit: present the next MOSI bit.
                     bit_cnt   <= bit_cnt + 6'd1;
                     tx        <= {tx[29:0], 1'b0};
                     flash_io0 <= (bit_cnt < 6'(CMD_BITS + ADDR_BITS - 1)) ? tx[30] : 1'b0;
                     if (bit_cnt == 6'(CMD_BITS - 1))
                        state <= S_ADDR;
                     else if (bit_cnt == 6'(CMD_BITS + ADDR_BITS - 1))
                        state <= S_DATA;
                     else if (bit_cnt == 6'(TOT_BITS - 1)) begin
                        state     <= S_DONE;
                        flash_csb <= 1'b1;
                        if (sel) begin
                           p1_ack <= 1'b1;
                           p1_dat <= bswap32(rx);
                        end else begin
                           p0_ack <= 1'b1;
                           p0_dat <= bswap32(rx);
                        end
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 16'd1;
               end
            end
            S_DONE: begin
               desel_cnt <= '0;
               state     <= S_DESEL;
            end
            S_DESEL: begin
               if (desel_cnt == 16'(DESEL_CYC - 1)) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  desel_cnt <= desel_cnt + 16'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
